// File: rtl/rv32i_types.sv
// Shared RV32I type aliases used by the memory-side blocks.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

endpackage

// File: rtl/mem_array.sv
// Word-addressed backing store: combinational read port and
// byte-enabled synchronous write port. Contents are never reset.
module mem_array
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  addr,
  input  rv32i_word      wdata,
  input  rv32i_mem_wmask be,
  output rv32i_word      rdata
);

  rv32i_word mem [DEPTH_WORDS];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one read/write, waits LATENCY
// cycles, pulses mem_resp, then spends one DRAIN cycle before re-accepting.
module mem_responder
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mem_read,
  input  logic           mem_write,
  input  rv32i_word      mem_address,
  input  rv32i_word      mem_wdata,
  input  rv32i_mem_wmask mem_byte_enable,
  output rv32i_word      mem_rdata,
  output logic           mem_resp,
  output logic           proto_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] COUNT_INIT = CW'(LATENCY - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  addr_q, addr_d;
  rv32i_word      wdata_q, wdata_d;
  rv32i_mem_wmask be_q, be_d;
  logic           is_write_q, is_write_d;
  logic           proto_err_q, proto_err_d;
  rv32i_word      arr_rdata;
  logic           unused_addr;

  // Only the word-index bits select storage; the rest wrap or are ignored.
  assign unused_addr = ^{mem_address[31:AW+2], mem_address[1:0]};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    is_write_d  = is_write_q;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          addr_d     = mem_address[AW+1:2];
          wdata_d    = mem_wdata;
          be_d       = mem_byte_enable;
          is_write_d = mem_write;
          if (mem_read && mem_write) proto_err_d = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
            count_d = '0;
          end else begin
            state_d = BUSY;
            count_d = COUNT_INIT;
          end
        end
      end
      BUSY: begin
        if (!mem_read && !mem_write) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == '0) begin
          state_d = RESP;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      RESP:    state_d = DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      is_write_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      is_write_q  <= is_write_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign mem_resp  = (state_q == RESP);
  assign proto_err = proto_err_q;
  assign mem_rdata = (mem_resp && !is_write_q) ? arr_rdata : '0;

  // The write commits on the edge that ends RESP, so a reset inside RESP drops it.
  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_resp && is_write_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (arr_rdata)
  );

endmodule
